// File: rtl/sgm_path_aggr.sv
// sgm_path_aggr: single-direction SGM path-cost aggregator, 4-stage pipeline.
//   Lr(p,d) = C(p,d) + min(Lr'(d), Lr'(d-1)+P1, Lr'(d+1)+P1, minLr'+P2) - minLr'
// All lane arithmetic saturates to 2^PIX_W-1. col==0 marks a path start (Lr = C).
//
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   in_valid/ready   input handshake; in_ready = !out_valid || out_ready
//   cost_init        C(p,d), lane d at [PIX_W*d +: PIX_W]
//   cost_aggr_last   Lr'(d) of the previous pixel on the path
//   row, col         coordinate tags carried alongside the data
//   out_valid/ready  output handshake
//   cost_aggr        Lr(p,d)
//   out_row, out_col tags aligned with cost_aggr
//   min_aggr         minimum over all lanes of cost_aggr (only with SGM_MIN_OUT_EN)
//
// Build option: define SGM_MIN_OUT_EN to add the min_aggr output.

module sgm_path_aggr #(
    parameter int unsigned DISP_RANGE = 108,
    parameter int unsigned PIX_W      = 8,
    parameter int unsigned P1         = 2,
    parameter int unsigned P2         = 16,
    parameter int unsigned COORD_W    = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DISP_RANGE*PIX_W-1:0] cost_init,
    input  logic [DISP_RANGE*PIX_W-1:0] cost_aggr_last,
    input  logic [COORD_W-1:0]          row,
    input  logic [COORD_W-1:0]          col,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DISP_RANGE*PIX_W-1:0] cost_aggr,
    output logic [COORD_W-1:0]          out_row,
    output logic [COORD_W-1:0]          out_col
`ifdef SGM_MIN_OUT_EN
    ,
    output logic [PIX_W-1:0]            min_aggr
`endif
);

    localparam int unsigned SUM_W  = PIX_W + 2;
    localparam int unsigned TREE_N = 1 << $clog2(DISP_RANGE);

    typedef logic [PIX_W-1:0]                  lane_t;
    typedef logic [DISP_RANGE-1:0][PIX_W-1:0]  vec_t;

    localparam lane_t LANE_MAX = '1;

    // Lower-index operand wins ties.
    function automatic lane_t min2(input lane_t lo_idx, input lane_t hi_idx);
        return (hi_idx < lo_idx) ? hi_idx : lo_idx;
    endfunction

    // a + k computed one bit wider, then clamped to the lane maximum.
    function automatic lane_t sat_add(input lane_t a, input int unsigned k);
        logic [PIX_W:0] wide;
        wide = {1'b0, a} + (PIX_W+1)'(k);
        return wide[PIX_W] ? LANE_MAX : wide[PIX_W-1:0];
    endfunction

    // Balanced min-reduction; padding leaves are all-ones so real lanes win ties.
    function automatic lane_t min_tree(input vec_t v);
        lane_t node [2*TREE_N];
        node[0] = LANE_MAX;
        for (int i = 0; i < int'(TREE_N); i++) begin
            node[int'(TREE_N) + i] = (i < int'(DISP_RANGE)) ? v[i] : LANE_MAX;
        end
        for (int i = int'(TREE_N) - 1; i >= 1; i--) begin
            node[i] = min2(node[2*i], node[2*i+1]);
        end
        return node[1];
    endfunction

    // C + m - minLr' in PIX_W+2 bits; never negative because m >= minLr'.
    function automatic lane_t finish_lane(input lane_t c, input lane_t m, input lane_t mn);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(c) + SUM_W'(m) - SUM_W'(mn);
        return (sum > SUM_W'(LANE_MAX)) ? LANE_MAX : sum[PIX_W-1:0];
    endfunction

    // Whole pipeline moves together; a stalled output freezes every stage.
    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Stage 1: registered inputs
    logic               s1_valid;
    vec_t               s1_cost;
    vec_t               s1_last;
    logic [COORD_W-1:0] s1_row;
    logic [COORD_W-1:0] s1_col;

    // Stage 2: candidates
    logic               s2_valid;
    vec_t               s2_cost;
    vec_t               s2_same;
    vec_t               s2_lo;
    vec_t               s2_hi;
    lane_t              s2_p2;
    lane_t              s2_min;
    logic               s2_start;
    logic [COORD_W-1:0] s2_row;
    logic [COORD_W-1:0] s2_col;

    // Stage 3: per-lane minimum
    logic               s3_valid;
    vec_t               s3_cost;
    vec_t               s3_m;
    lane_t              s3_min;
    logic               s3_start;
    logic [COORD_W-1:0] s3_row;
    logic [COORD_W-1:0] s3_col;

    vec_t  s2_lo_c;
    vec_t  s2_hi_c;
    lane_t s2_min_c;
    lane_t s2_p2_c;
    vec_t  s3_m_c;
    vec_t  s4_res_c;

    // S2: global minimum of Lr' and the neighbour/jump candidates; edge lanes get all-ones.
    always_comb begin
        s2_min_c = min_tree(s1_last);
        s2_p2_c  = sat_add(s2_min_c, P2);
        s2_lo_c  = '1;
        s2_hi_c  = '1;
        for (int d = 1; d < int'(DISP_RANGE); d++) begin
            s2_lo_c[d] = sat_add(s1_last[d-1], P1);
        end
        for (int d = 0; d + 1 < int'(DISP_RANGE); d++) begin
            s2_hi_c[d] = sat_add(s1_last[d+1], P1);
        end
    end

    // S3: minimum of the four candidates, evaluated in recurrence order.
    always_comb begin
        s3_m_c = '1;
        for (int d = 0; d < int'(DISP_RANGE); d++) begin
            s3_m_c[d] = min2(min2(s2_same[d], s2_lo[d]), min2(s2_hi[d], s2_p2));
        end
    end

    // S4: final sum, or the raw cost at a path start.
    always_comb begin
        s4_res_c = '1;
        for (int d = 0; d < int'(DISP_RANGE); d++) begin
            s4_res_c[d] = s3_start ? s3_cost[d] : finish_lane(s3_cost[d], s3_m[d], s3_min);
        end
    end

`ifdef SGM_MIN_OUT_EN
    lane_t s4_min_c;
    always_comb begin
        s4_min_c = min_tree(s4_res_c);
    end
`endif

    // Valid bits and the output register; these are the only state with a reset value.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s3_valid  <= 1'b0;
            out_valid <= 1'b0;
            cost_aggr <= '1;
            out_row   <= '0;
            out_col   <= '0;
`ifdef SGM_MIN_OUT_EN
            min_aggr  <= '1;
`endif
        end else if (advance) begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            s3_valid  <= s2_valid;
            out_valid <= s3_valid;
            cost_aggr <= s4_res_c;
            out_row   <= s3_row;
            out_col   <= s3_col;
`ifdef SGM_MIN_OUT_EN
            min_aggr  <= s4_min_c;
`endif
        end
    end

    // Datapath stages; contents behind a cleared valid are don't-care.
    always_ff @(posedge clk) begin
        if (advance) begin
            s1_cost  <= cost_init;
            s1_last  <= cost_aggr_last;
            s1_row   <= row;
            s1_col   <= col;

            s2_cost  <= s1_cost;
            s2_same  <= s1_last;
            s2_lo    <= s2_lo_c;
            s2_hi    <= s2_hi_c;
            s2_p2    <= s2_p2_c;
            s2_min   <= s2_min_c;
            s2_start <= (s1_col == '0);
            s2_row   <= s1_row;
            s2_col   <= s1_col;

            s3_cost  <= s2_cost;
            s3_m     <= s3_m_c;
            s3_min   <= s2_min;
            s3_start <= s2_start;
            s3_row   <= s2_row;
            s3_col   <= s2_col;
        end
    end

endmodule

// File: tb/tb_sgm_path_aggr.sv
// Scoreboard bench for sgm_path_aggr with DISP_RANGE=4, PIX_W=8, P1=2, P2=16.
module tb_sgm_path_aggr;

    localparam int unsigned DR = 4;
    localparam int unsigned PW = 8;
    localparam int unsigned CW = 10;
    localparam int unsigned VW = DR * PW;
    localparam int unsigned NV = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [VW-1:0] cost_init;
    logic [VW-1:0] cost_aggr_last;
    logic [CW-1:0] row;
    logic [CW-1:0] col;
    logic          out_valid;
    logic          out_ready;
    logic [VW-1:0] cost_aggr;
    logic [CW-1:0] out_row;
    logic [CW-1:0] out_col;
`ifdef SGM_MIN_OUT_EN
    logic [PW-1:0] min_aggr;
`endif

    sgm_path_aggr #(
        .DISP_RANGE(DR), .PIX_W(PW), .P1(2), .P2(16), .COORD_W(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .cost_init(cost_init), .cost_aggr_last(cost_aggr_last),
        .row(row), .col(col),
        .out_valid(out_valid), .out_ready(out_ready),
        .cost_aggr(cost_aggr), .out_row(out_row), .out_col(out_col)
`ifdef SGM_MIN_OUT_EN
        , .min_aggr(min_aggr)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [VW-1:0] cost;
        logic [CW-1:0] row;
        logic [CW-1:0] col;
        logic [PW-1:0] mn;
        int            acc;
        bit            lat;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   stall_samples = 0;

    logic [VW-1:0] t_cost [NV];
    logic [VW-1:0] t_last [NV];
    logic [VW-1:0] t_exp  [NV];
    logic [PW-1:0] t_min  [NV];
    logic [CW-1:0] t_col  [NV];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [VW-1:0] p4(input int a0, input int a1, input int a2, input int a3);
        return {PW'(a3), PW'(a2), PW'(a1), PW'(a0)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Present table vector idx with the given row tag; returns after the accepting edge.
    task automatic send(input int idx, input logic [CW-1:0] r, input bit lat);
        exp_t e;
        int   waitc;
        @(negedge clk); #1;
        in_valid       = 1'b1;
        cost_init      = t_cost[idx];
        cost_aggr_last = t_last[idx];
        row            = r;
        col            = t_col[idx];
        #1;
        waitc = 0;
        while (!in_ready) begin
            @(negedge clk); #2;
            waitc++;
            if (waitc > 100) begin
                chk("send_timeout", 64'(waitc), 64'(0));
                in_valid = 1'b0;
                return;
            end
        end
        e.cost = t_exp[idx];
        e.row  = r;
        e.col  = t_col[idx];
        e.mn   = t_min[idx];
        e.acc  = cyc;
        e.lat  = lat;
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int waitc = 0;
        while (exp_q.size() != 0 && waitc < 200) begin
            @(negedge clk);
            waitc++;
        end
        chk("drain_left", 64'(exp_q.size()), 64'(0));
    endtask

    // Monitor: pops on every output handshake and checks hold behaviour during stalls.
    logic          prev_stall = 1'b0;
    logic [VW-1:0] prev_cost;
    logic [CW-1:0] prev_row;
    logic [CW-1:0] prev_col;

    always @(negedge clk) begin
        #3;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 64'(out_valid), 64'(1));
                chk("stall_cost", 64'(cost_aggr), 64'(prev_cost));
                chk("stall_row", 64'(out_row), 64'(prev_row));
                chk("stall_col", 64'(out_col), 64'(prev_col));
            end
            if (out_valid && !out_ready) begin
                stall_samples++;
                chk("stall_in_ready", 64'(in_ready), 64'(0));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_row", 64'(out_row), 64'h3ff_ffff);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("cost_aggr", 64'(cost_aggr), 64'(e.cost));
                    chk("out_row", 64'(out_row), 64'(e.row));
                    chk("out_col", 64'(out_col), 64'(e.col));
`ifdef SGM_MIN_OUT_EN
                    chk("min_aggr", 64'(min_aggr), 64'(e.mn));
`endif
                    if (e.lat) chk("latency", 64'(cyc - e.acc), 64'(4));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_cost  = cost_aggr;
            prev_row   = out_row;
            prev_col   = out_col;
        end
    end

    task automatic chk_reset_state(input string tag);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
        chk({tag, "_cost_aggr"}, 64'(cost_aggr), 64'({VW{1'b1}}));
        chk({tag, "_out_row"}, 64'(out_row), 64'(0));
        chk({tag, "_out_col"}, 64'(out_col), 64'(0));
        chk({tag, "_in_ready"}, 64'(in_ready), 64'(1));
`ifdef SGM_MIN_OUT_EN
        chk({tag, "_min_aggr"}, 64'(min_aggr), 64'({PW{1'b1}}));
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Path start, recurrence, saturation and jump-penalty vectors, computed by hand.
        t_cost[0] = p4(10, 20, 30, 40);     t_last[0] = p4(99, 1, 7, 200);
        t_col[0]  = 0;  t_exp[0] = p4(10, 20, 30, 40);     t_min[0] = 10;
        t_cost[1] = p4(5, 5, 5, 5);         t_last[1] = p4(0, 50, 3, 60);
        t_col[1]  = 1;  t_exp[1] = p4(5, 7, 8, 10);        t_min[1] = 5;
        t_cost[2] = p4(250, 250, 250, 250); t_last[2] = p4(0, 0, 0, 0);
        t_col[2]  = 2;  t_exp[2] = p4(250, 250, 250, 250); t_min[2] = 250;
        t_cost[3] = p4(255, 255, 255, 255); t_last[3] = p4(100, 200, 255, 255);
        t_col[3]  = 3;  t_exp[3] = p4(255, 255, 255, 255); t_min[3] = 255;
        t_cost[4] = p4(1, 2, 3, 4);         t_last[4] = p4(40, 20, 30, 10);
        t_col[4]  = 4;  t_exp[4] = p4(13, 12, 5, 4);       t_min[4] = 4;
        t_cost[5] = p4(0, 0, 0, 0);         t_last[5] = p4(0, 100, 100, 100);
        t_col[5]  = 5;  t_exp[5] = p4(0, 2, 16, 16);       t_min[5] = 0;
        t_cost[6] = p4(0, 0, 0, 0);         t_last[6] = p4(255, 254, 255, 255);
        t_col[6]  = 6;  t_exp[6] = p4(1, 0, 1, 1);         t_min[6] = 0;

        rst            = 1'b1;
        in_valid       = 1'b0;
        out_ready      = 1'b1;
        cost_init      = '0;
        cost_aggr_last = '0;
        row            = '0;
        col            = '0;
        repeat (3) @(negedge clk);
        #2;
        chk_reset_state("init");
        @(negedge clk); #1;
        rst = 1'b0;

        // Back-to-back stream, no backpressure: exact latency checked.
        for (int i = 0; i < int'(NV); i++) send(i, CW'(i + 1), 1'b1);
        idle();
        drain();

        // Six beats with out_ready low for three cycles mid-stream.
        fork
            begin
                for (int i = 0; i < 6; i++) send(i, CW'(20 + i), 1'b0);
                idle();
            end
            begin
                repeat (6) @(negedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(negedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_stall_seen", 64'(stall_samples > 0), 64'(1));

        // Reset with three beats in flight; they must vanish.
        for (int i = 1; i < 4; i++) send(i, CW'(40 + i), 1'b0);
        @(negedge clk); #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk); #2;
        chk_reset_state("midrst");
        exp_q.delete();
        @(negedge clk); #1;
        rst = 1'b0;

        // Traffic after reset keeps the 4-cycle latency.
        send(4, CW'(50), 1'b1);
        send(0, CW'(51), 1'b1);
        idle();
        drain();
        repeat (8) @(negedge clk);
        chk("final_queue", 64'(exp_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
